// File: rtl/plane_move_ctrl.sv
// -----------------------------------------------------------------------------
// plane_move_ctrl
//
// Player-plane motion and fire controller. Sits downstream of the 20 ms frame
// divider. The divider's slow square wave is treated as data: each rising edge
// seen in the clk domain is one frame event. On every frame event the five
// push buttons are debounced, the plane's top-left X/Y is stepped (clamped to
// the screen) and a rate-limited fire request may be issued.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   tick_in     slow square wave from the frame divider
//   enable      game running; when low the plane freezes and fire is held off
//   btn_up, btn_down, btn_left, btn_right, btn_fire
//               raw asynchronous push buttons
//   plane_x     sprite X, 0..SCR_W-PLANE_W
//   plane_y     sprite Y, 0..SCR_H-PLANE_H
//   frame_tick  one-clk pulse per frame event
//   fire_req    one-clk shot request, coincident with frame_tick
//
// Build option:
//   PLANE_WRAP_EN  when defined, horizontal motion wraps around the screen
//                  edges instead of clamping. Vertical motion always clamps.
// -----------------------------------------------------------------------------
module plane_move_ctrl #(
  parameter int SCR_W         = 640,
  parameter int SCR_H         = 480,
  parameter int PLANE_W       = 40,
  parameter int PLANE_H       = 40,
  parameter int STEP          = 4,
  parameter int X_INIT        = 300,
  parameter int Y_INIT        = 420,
  parameter int DEB_TICKS     = 2,
  parameter int FIRE_COOLDOWN = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       enable,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_fire,
  output logic [9:0] plane_x,
  output logic [9:0] plane_y,
  output logic       frame_tick,
  output logic       fire_req
);

  localparam int NBTN   = 5;
  localparam int B_UP    = 0;
  localparam int B_DOWN  = 1;
  localparam int B_LEFT  = 2;
  localparam int B_RIGHT = 3;
  localparam int B_FIRE  = 4;

  localparam logic [9:0]  X_MAX    = 10'(SCR_W - PLANE_W);
  localparam logic [9:0]  Y_MAX    = 10'(SCR_H - PLANE_H);
  localparam logic [9:0]  STEP10   = 10'(STEP);
  localparam logic [10:0] STEP11   = 11'(STEP);
  localparam logic [9:0]  X_RESET  = 10'(X_INIT);
  localparam logic [9:0]  Y_RESET  = 10'(Y_INIT);
  localparam logic [2:0]  DEB_MAX  = 3'(DEB_TICKS);
  localparam logic [7:0]  COOL_MAX = 8'(FIRE_COOLDOWN);

  // Where X lands when a step would leave the screen on either side.
`ifdef PLANE_WRAP_EN
  localparam logic [9:0] X_UNDER = X_MAX;
  localparam logic [9:0] X_OVER  = 10'd0;
`else
  localparam logic [9:0] X_UNDER = 10'd0;
  localparam logic [9:0] X_OVER  = X_MAX;
`endif

  // ---------------------------------------------------------------------------
  // Frame event detection
  // ---------------------------------------------------------------------------
  logic tick_q_reg;
  logic tick_qq_reg;
  logic primed_reg;   // tick_q holds a real sample of tick_in, not its reset value
  logic armed_reg;    // a low level has been seen since reset
  logic frame_event;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q_reg  <= 1'b0;
      tick_qq_reg <= 1'b0;
      primed_reg  <= 1'b0;
      armed_reg   <= 1'b0;
    end else begin
      tick_q_reg  <= tick_in;
      tick_qq_reg <= tick_q_reg;
      primed_reg  <= 1'b1;
      // Without primed_reg the reset value of tick_q would arm us even when
      // tick_in is already high at reset release, giving a spurious frame.
      if (primed_reg && !tick_q_reg) begin
        armed_reg <= 1'b1;
      end
    end
  end

  assign frame_event = tick_q_reg & ~tick_qq_reg & armed_reg;

  // ---------------------------------------------------------------------------
  // Button synchronisers and per-button frame debounce
  // ---------------------------------------------------------------------------
  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] btn_s1_reg;
  logic [NBTN-1:0] btn_s2_reg;
  logic [NBTN-1:0] pressed;

  assign btn_raw = {btn_fire, btn_right, btn_left, btn_down, btn_up};

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1_reg <= '0;
      btn_s2_reg <= '0;
    end else begin
      btn_s1_reg <= btn_raw;
      btn_s2_reg <= btn_s1_reg;
    end
  end

  for (genvar gi = 0; gi < NBTN; gi++) begin : g_deb
    logic [2:0] cnt_reg;
    logic [2:0] cnt_next;

    always_comb begin
      cnt_next = cnt_reg;
      if (frame_event) begin
        if (!enable || !btn_s2_reg[gi]) begin
          cnt_next = 3'd0;
        end else if (cnt_reg != DEB_MAX) begin
          cnt_next = cnt_reg + 3'd1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg <= 3'd0;
      end else begin
        cnt_reg <= cnt_next;
      end
    end

    // Pressed only means something on an enabled frame event; the saturated
    // count keeps a held button active on every later frame.
    assign pressed[gi] = frame_event && enable && (cnt_next == DEB_MAX);
  end

  // ---------------------------------------------------------------------------
  // Motion
  // ---------------------------------------------------------------------------
  logic [9:0] x_reg, x_next;
  logic [9:0] y_reg, y_next;

  always_comb begin
    x_next = x_reg;
    y_next = y_reg;

    // Opposite directions pressed together cancel out.
    if (pressed[B_LEFT] && !pressed[B_RIGHT]) begin
      if (x_reg < STEP10) begin
        x_next = X_UNDER;
      end else begin
        x_next = x_reg - STEP10;
      end
    end else if (pressed[B_RIGHT] && !pressed[B_LEFT]) begin
      // Compare one bit wider so the sum cannot wrap before the test.
      if ({1'b0, x_reg} + STEP11 > {1'b0, X_MAX}) begin
        x_next = X_OVER;
      end else begin
        x_next = x_reg + STEP10;
      end
    end

    if (pressed[B_UP] && !pressed[B_DOWN]) begin
      if (y_reg < STEP10) begin
        y_next = 10'd0;
      end else begin
        y_next = y_reg - STEP10;
      end
    end else if (pressed[B_DOWN] && !pressed[B_UP]) begin
      if ({1'b0, y_reg} + STEP11 > {1'b0, Y_MAX}) begin
        y_next = Y_MAX;
      end else begin
        y_next = y_reg + STEP10;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fire rate limiter
  // ---------------------------------------------------------------------------
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_COOL = 1'b1
  } fire_state_t;

  fire_state_t state_reg, state_next;
  logic [7:0]  cool_reg, cool_next;
  logic        fire_next;

  always_comb begin
    state_next = state_reg;
    cool_next  = cool_reg;
    fire_next  = 1'b0;
    if (frame_event) begin
      if (!enable) begin
        state_next = ST_IDLE;
        cool_next  = 8'd0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (pressed[B_FIRE]) begin
              fire_next  = 1'b1;
              cool_next  = COOL_MAX;
              state_next = ST_COOL;
            end
          end
          ST_COOL: begin
            // Leaving on the frame the count hits zero lets a held button
            // fire again on the very next frame.
            if (cool_reg <= 8'd1) begin
              cool_next  = 8'd0;
              state_next = ST_IDLE;
            end else begin
              cool_next = cool_reg - 8'd1;
            end
          end
          default: begin
            state_next = ST_IDLE;
            cool_next  = 8'd0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  logic frame_tick_reg;
  logic fire_req_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg          <= X_RESET;
      y_reg          <= Y_RESET;
      state_reg      <= ST_IDLE;
      cool_reg       <= 8'd0;
      frame_tick_reg <= 1'b0;
      fire_req_reg   <= 1'b0;
    end else begin
      x_reg          <= x_next;
      y_reg          <= y_next;
      state_reg      <= state_next;
      cool_reg       <= cool_next;
      frame_tick_reg <= frame_event;
      fire_req_reg   <= fire_next;
    end
  end

  assign plane_x    = x_reg;
  assign plane_y    = y_reg;
  assign frame_tick = frame_tick_reg;
  assign fire_req   = fire_req_reg;

endmodule

// File: tb/tb_plane_move_ctrl.sv
// -----------------------------------------------------------------------------
// tb_plane_move_ctrl
//
// Scoreboard bench for plane_move_ctrl. The stimulus process drives one frame
// at a time (tick_in low for 8 clk, high for 8 clk), changing buttons and
// enable only while tick_in is low. Just before each rising edge it runs a
// frame-level reference model and queues the expected position, fire flag and
// the clk count at which frame_tick must appear. A separate monitor pops the
// queue whenever frame_tick is seen and compares.
// -----------------------------------------------------------------------------
module tb_plane_move_ctrl;

  localparam int STEP  = 4;
  localparam int XMAX  = 640 - 40;
  localparam int YMAX  = 480 - 40;
  localparam int X0    = 300;
  localparam int Y0    = 420;
  localparam int DEB   = 2;
  localparam int COOL  = 10;

  // Button vector order: {fire, right, left, down, up}
  localparam int I_UP = 0, I_DOWN = 1, I_LEFT = 2, I_RIGHT = 3, I_FIRE = 4;
  localparam logic [4:0] B_NONE  = 5'b00000;
  localparam logic [4:0] B_UP    = 5'b00001;
  localparam logic [4:0] B_DOWN  = 5'b00010;
  localparam logic [4:0] B_LEFT  = 5'b00100;
  localparam logic [4:0] B_RIGHT = 5'b01000;
  localparam logic [4:0] B_FIRE  = 5'b10000;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_in;
  logic       enable;
  logic       btn_up, btn_down, btn_left, btn_right, btn_fire;
  logic [9:0] plane_x, plane_y;
  logic       frame_tick, fire_req;

  plane_move_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .tick_in    (tick_in),
    .enable     (enable),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_fire   (btn_fire),
    .plane_x    (plane_x),
    .plane_y    (plane_y),
    .frame_tick (frame_tick),
    .fire_req   (fire_req)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  task automatic check(string name, int act, int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  typedef struct {
    int x;
    int y;
    int fire;
    int when;
    int idx;
  } exp_t;

  exp_t sb[$];

  // ---------------------------------------------------------------------------
  // Reference model (frame level)
  // ---------------------------------------------------------------------------
  int  mx, my;
  int  run[5];          // consecutive enabled high frames per button
  int  fidx;            // frame counter
  int  last_shot;
  bit  shot_valid;

  task automatic model_reset();
    mx = X0;
    my = Y0;
    for (int i = 0; i < 5; i++) run[i] = 0;
    shot_valid = 1'b0;
    last_shot  = 0;
  endtask

  task automatic model_frame(input logic [4:0] b, input bit en, output int fire);
    bit l, r, u, d, f;
    fidx++;
    fire = 0;
    for (int i = 0; i < 5; i++) run[i] = (en && b[i]) ? run[i] + 1 : 0;
    if (!en) begin
      shot_valid = 1'b0;
      return;
    end
    u = run[I_UP]    >= DEB;
    d = run[I_DOWN]  >= DEB;
    l = run[I_LEFT]  >= DEB;
    r = run[I_RIGHT] >= DEB;
    f = run[I_FIRE]  >= DEB;
`ifdef PLANE_WRAP_EN
    if (l && !r)      mx = (mx - STEP < 0)    ? XMAX : mx - STEP;
    else if (r && !l) mx = (mx + STEP > XMAX) ? 0    : mx + STEP;
`else
    if (l && !r)      mx = (mx - STEP < 0)    ? 0    : mx - STEP;
    else if (r && !l) mx = (mx + STEP > XMAX) ? XMAX : mx + STEP;
`endif
    if (u && !d)      my = (my - STEP < 0)    ? 0    : my - STEP;
    else if (d && !u) my = (my + STEP > YMAX) ? YMAX : my + STEP;
    // A shot blocks the next COOL frames.
    if (f && (!shot_valid || (fidx - last_shot) > COOL)) begin
      fire       = 1;
      shot_valid = 1'b1;
      last_shot  = fidx;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step_clk(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btns(input logic [4:0] b);
    {btn_fire, btn_right, btn_left, btn_down, btn_up} = b;
  endtask

  // One frame: low phase (inputs change here, optional reset), then the rise.
  // rst_at in 1..4 pulses rst for one clk that many clk into the low phase.
  task automatic do_frame(input logic [4:0] b, input bit en, input int rst_at);
    exp_t e;
    int   fire;
    tick_in = 1'b0;
    set_btns(b);
    enable = en;
    if (rst_at > 0) begin
      step_clk(rst_at);
      rst = 1'b1;
      step_clk(1);
      rst = 1'b0;
      model_reset();
      check("midrst_plane_x", int'(plane_x), X0);
      check("midrst_plane_y", int'(plane_y), Y0);
      check("midrst_fire_req", int'(fire_req), 0);
      step_clk(8 - rst_at - 1);
    end else begin
      step_clk(8);
    end
    model_frame(b, en, fire);
    e.x    = mx;
    e.y    = my;
    e.fire = fire;
    e.when = cyc + 2;
    e.idx  = fidx;
    sb.push_back(e);
    tick_in = 1'b1;
    step_clk(8);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  bit prev_ft = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (prev_ft) check("frame_tick_width", int'(frame_tick), 0);
    if (fire_req) check("fire_with_frame_tick", int'(frame_tick), 1);
    if (frame_tick) begin
      if (sb.size() == 0) begin
        check("frame_tick_expected", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check("event_cycle", cyc, e.when);
        check("plane_x", int'(plane_x), e.x);
        check("plane_y", int'(plane_y), e.y);
        check("fire_req", int'(fire_req), e.fire);
        $display("frame %0d: x=%0d y=%0d fire=%0d (exp x=%0d y=%0d fire=%0d)",
                 e.idx, plane_x, plane_y, fire_req, e.x, e.y, e.fire);
      end
    end
    prev_ft = frame_tick;
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [4:0] rb;
    bit         ren;
    int         rr;

    fidx = 0;
    model_reset();
    rst     = 1'b1;
    tick_in = 1'b1;
    enable  = 1'b1;
    set_btns(B_RIGHT);
    step_clk(3);
    rst = 1'b0;
    check("reset_plane_x", int'(plane_x), X0);
    check("reset_plane_y", int'(plane_y), Y0);
    check("reset_fire_req", int'(fire_req), 0);
    check("reset_frame_tick", int'(frame_tick), 0);
    // tick_in stays high: any frame_tick now is unexpected (queue is empty).
    step_clk(10);

    // Debounce: held right moves on the 2nd frame onward; re-press restarts.
    repeat (3) do_frame(B_RIGHT, 1'b1, 0);
    do_frame(B_NONE, 1'b1, 0);
    repeat (2) do_frame(B_RIGHT, 1'b1, 0);

    // Edges of the screen.
    repeat (80)  do_frame(B_RIGHT, 1'b1, 0);
    repeat (160) do_frame(B_LEFT,  1'b1, 0);
    repeat (3)   do_frame(B_RIGHT, 1'b1, 0);
    repeat (3)   do_frame(B_LEFT,  1'b1, 0);
    repeat (110) do_frame(B_UP,    1'b1, 0);
    repeat (112) do_frame(B_DOWN,  1'b1, 0);

    // Left and right cancel while up still moves.
    repeat (10) do_frame(B_LEFT | B_RIGHT | B_UP, 1'b1, 0);

    // Held fire: one shot every COOL+1 frames.
    do_frame(B_NONE, 1'b1, 0);
    repeat (30) do_frame(B_FIRE, 1'b1, 0);

    // Reset in the middle of cooldown and motion.
    repeat (4) do_frame(B_FIRE | B_RIGHT, 1'b1, 0);
    do_frame(B_FIRE | B_RIGHT, 1'b1, 3);
    repeat (4) do_frame(B_FIRE | B_RIGHT, 1'b1, 0);

    // Disabled: frames still tick, nothing moves or fires.
    repeat (6) do_frame(5'b11111, 1'b0, 0);
    repeat (4) do_frame(B_FIRE | B_DOWN, 1'b1, 0);

    // Randomized frames.
    for (int i = 0; i < 250; i++) begin
      for (int k = 0; k < 5; k++) rb[k] = ($urandom_range(0, 99) < 65);
      ren = ($urandom_range(0, 99) < 90);
      rr  = ($urandom_range(0, 29) == 0) ? int'($urandom_range(1, 4)) : 0;
      do_frame(rb, ren, rr);
    end

    tick_in = 1'b0;
    step_clk(4);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

endmodule
